// File: rtl/fifo_uart_rx.sv
// fifo_uart_rx: 8-bit UART receiver that pushes good bytes into a downstream FIFO.
// Frame: start bit, 8 data bits LSB-first, optional even-parity bit, one stop bit.
// Optional feature: define UART_PARITY_EN to compile in the even-parity bit.
// Each bit is sampled once, near its centre, CLKS_PER_BIT clk0 cycles apart.
module fifo_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk0,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       fifo_full,
  output logic [7:0] in_FIFO,
  output logic       write_enable,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] FULL_M1 = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction
`endif

  // rx_meta_q/rx_sync_q form the synchronizer; rx_prev_q lets IDLE see a falling edge.
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  state_t     state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       err_wait_q, err_wait_d;
  logic [7:0] in_fifo_q, in_fifo_d;
  logic       we_q, we_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;
  logic       busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic       par_err_q, par_err_d;
`endif
  logic       good_s;

  // Next-state and next-output computation for the receive FSM.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 10'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    err_wait_d = err_wait_q;
    in_fifo_d  = in_fifo_q;
    we_d       = 1'b0;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    good_s     = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (err_wait_q) begin
          // After a bad frame the line must be high for a full bit before re-arming.
          if (!rx_sync_q) begin
            timer_d = 10'd0;
          end else if (timer_q == FULL_M1) begin
            timer_d    = 10'd0;
            err_wait_d = 1'b0;
          end else begin
            timer_d = timer_q + 10'd1;
          end
        end else begin
          timer_d = 10'd0;
          if (rx_prev_q && !rx_sync_q) begin
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = 10'd0;
          bit_idx_d = 3'd0;
`ifdef UART_PARITY_EN
          par_err_d = 1'b0;
`endif
          // A line that is high again at mid start bit was only a glitch.
          if (!rx_sync_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d   = 10'd0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (timer_q == FULL_M1) begin
          timer_d   = 10'd0;
          par_err_d = (rx_sync_q != even_parity(shift_q));
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = 10'd0;
          state_d = IDLE;
`ifdef UART_PARITY_EN
          good_s  = rx_sync_q && !par_err_q;
`else
          good_s  = rx_sync_q;
`endif
          if (!good_s) begin
            fe_d       = 1'b1;
            err_wait_d = 1'b1;
          end else if (fifo_full) begin
            ov_d = 1'b1;
          end else begin
            we_d      = 1'b1;
            in_fifo_d = shift_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 10'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state, synchronizer and registered outputs; reset forces a clean idle receiver.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      timer_q    <= 10'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      err_wait_q <= 1'b0;
      in_fifo_q  <= 8'h00;
      we_q       <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      err_wait_q <= err_wait_d;
      in_fifo_q  <= in_fifo_d;
      we_q       <= we_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign in_FIFO      = in_fifo_q;
  assign write_enable = we_q;
  assign frame_error  = fe_q;
  assign overrun      = ov_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_uart_rx.sv
// Bench for fifo_uart_rx at CLKS_PER_BIT=16: directed frames plus a frame-level model
// that predicts the cycle and kind of every output pulse and the held in_FIFO value.
module tb_fifo_uart_rx;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // Falling edge reaches the FSM after 2 sync cycles, the start bit is checked at mid-bit,
  // then 8 data bits (+ parity) and the stop bit each take one full bit.
  localparam int LAT = 2 + CPB / 2 + (8 + NPAR + 1) * CPB;

  localparam int K_WE = 0;
  localparam int K_FE = 1;
  localparam int K_OV = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk0 = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       fifo_full;
  logic [7:0] in_FIFO;
  logic       write_enable;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  ev_t        evq[$];
  int         we_cyc[$];
  int         n_we = 0;
  int         n_fe = 0;
  int         n_ov = 0;
  logic [7:0] model_data = 8'h00;

  fifo_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk0         (clk0),
    .reset_n      (reset_n),
    .rx           (rx),
    .fifo_full    (fifo_full),
    .in_FIFO      (in_FIFO),
    .write_enable (write_enable),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison of pulses and in_FIFO against the frame-level model.
  always begin
    logic ew, ef, eo;
    @(posedge clk0);
    cyc = cyc + 1;
    #1;
    ew = 1'b0; ef = 1'b0; eo = 1'b0;
    if (!reset_n) model_data = 8'h00;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev_t e;
      e = evq.pop_front();
      if (e.kind == K_WE) begin
        ew = 1'b1;
        model_data = e.data;
      end else if (e.kind == K_FE) begin
        ef = 1'b1;
      end else begin
        eo = 1'b1;
      end
    end
    check("outputs", {21'd0, write_enable, frame_error, overrun, in_FIFO},
          {21'd0, ew, ef, eo, model_data});
    if (write_enable === 1'b1) begin
      we_cyc.push_back(cyc);
      n_we++;
    end
    if (frame_error === 1'b1) n_fe++;
    if (overrun === 1'b1) n_ov++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk0);
  endtask

  // Drives one frame and records the pulse the specification demands for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    ev_t e;
    logic good;
    @(negedge clk0);
    good   = stop_b;
`ifdef UART_PARITY_EN
    good   = good && !bad_par;
`endif
    e.cyc  = cyc + 1 + LAT;
    e.data = d;
    e.kind = !good ? K_FE : (fifo_full ? K_OV : K_WE);
    evq.push_back(e);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(CPB);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ bad_par;
    hold(CPB);
`endif
    rx = stop_b;
    hold(CPB - 1);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    rx        = 1'b1;
    fifo_full = 1'b0;
    hold(5);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_fifo", {24'd0, in_FIFO}, 32'h00);
    reset_n = 1'b1;
    hold(40);

    // Single good byte.
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    check("a5_data", {24'd0, in_FIFO}, 32'hA5);
    hold(20);

    // Back-to-back frames.
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    hold(1);
    check("b2b_data", {24'd0, in_FIFO}, 32'hC3);
    if (we_cyc.size() >= 3) begin
      check("b2b_spacing", we_cyc[2] - we_cyc[1], 32'(160 + 16 * NPAR));
    end else begin
      check("b2b_we_seen", we_cyc.size(), 32'd3);
    end
    hold(20);

    // Bad stop bit.
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge clk0);
    rx = 1'b1;
    hold(40);
    check("fe_hold_data", {24'd0, in_FIFO}, 32'hC3);
    check("fe_count", n_fe, 32'd1);

    // Short glitch on an idle line.
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(6);
    check("glitch_busy_mid", {31'd0, busy}, 32'd1);
    hold(20);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    hold(20);

    // Downstream full.
    fifo_full = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    hold(2);
    fifo_full = 1'b0;
    check("ov_count", n_ov, 32'd1);
    check("ov_hold_data", {24'd0, in_FIFO}, 32'hC3);
    hold(20);

    // Reset during bit 4 of 0xFF.
    rx = 1'b0;
    hold(CPB);
    rx = 1'b1;
    hold(4 * CPB + CPB / 2);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    hold(10);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_fifo", {24'd0, in_FIFO}, 32'h00);
    reset_n = 1'b1;
    hold(40);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b1);
    hold(20);
`ifdef UART_PARITY_EN
    check("final_data", {24'd0, in_FIFO}, 32'h00);
    check("total_we", n_we, 32'd3);
    check("total_fe", n_fe, 32'd2);
`else
    check("final_data", {24'd0, in_FIFO}, 32'h12);
    check("total_we", n_we, 32'd4);
    check("total_fe", n_fe, 32'd1);
`endif
    check("total_ov", n_ov, 32'd1);
    check("events_pending", evq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_rx.md
FIFO_UART_RX -- requirements
Module: fifo_uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, clk0 cycles per serial bit; legal range 4..1023.
REQ-002 The module SHALL have port clk0, input, 1, single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-005 The module SHALL have port fifo_full, input, 1, downstream FIFO cannot accept a byte this cycle.
REQ-006 The module SHALL have port in_FIFO, output, 8, received byte, registered, drives downstream FIFO data input.
REQ-007 The module SHALL have port write_enable, output, 1, one-cycle strobe; in_FIFO valid while high.
REQ-008 The module SHALL have port frame_error, output, 1, one-cycle pulse on bad stop bit (or bad parity when enabled).
REQ-009 The module SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped because fifo_full=1.
REQ-010 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 The module SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, a synchronized rx=0 SHALL move to START and clear the bit-timer.
REQ-014 In START, at timer=CLKS_PER_BIT/2-1 (integer division), rx=0 SHALL move to DATA with timer cleared; rx=1 SHALL return to IDLE without any output pulse (glitch rejection).
REQ-015 In DATA, each time timer reaches CLKS_PER_BIT-1, rx SHALL be sampled into the shift register LSB-first, timer cleared, bit index incremented; after bit 7 the FSM SHALL go to PARITY (if enabled) or STOP.
REQ-016 In STOP, at timer=CLKS_PER_BIT-1, the FSM SHALL evaluate the stop bit and return to IDLE on the next edge.
REQ-017 Good frame (stop=1, parity ok) with fifo_full=0 SHALL load in_FIFO and assert write_enable for exactly one cycle, on the edge the FSM returns to IDLE.
REQ-018 Good frame with fifo_full=1 at that edge SHALL leave in_FIFO unchanged, keep write_enable low, pulse overrun one cycle.
REQ-019 Bad frame SHALL keep write_enable low, leave in_FIFO unchanged, pulse frame_error one cycle; overrun SHALL not pulse.
REQ-020 After a frame error, the FSM SHALL wait in IDLE until rx is high for one full bit time before accepting a new start bit.
REQ-021 Timer SHALL be 10 bits and reset to 0 on every state change; bit index SHALL be 3 bits and wrap to 0 after bit 7.
REQ-022 write_enable, frame_error and overrun SHALL be mutually exclusive in any cycle.
REQ-023 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state IDLE, timer 0, bit index 0, shift register 0x00, synchronizer flops 1.
REQ-025 During reset, in_FIFO SHALL be 0x00 and write_enable, frame_error, overrun, busy SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a fresh falling edge of rx.

Configuration
REQ-027 Macro UART_PARITY_EN SHALL compile in the PARITY state: with it defined, one even-parity bit follows bit 7, sampled at timer=CLKS_PER_BIT-1; mismatch SHALL be reported as frame_error per REQ-019.
REQ-028 Without UART_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=16)
REQ-029 Send 0xA5, stop=1, fifo_full=0 -> one write_enable pulse with in_FIFO=0xA5, no error pulses, busy low afterwards.
REQ-030 Send 0x3C then 0xC3 back-to-back -> two write_enable pulses, values 0x3C then 0xC3, 160 cycles apart (176 with UART_PARITY_EN).
REQ-031 Send 0x55 with stop bit driven 0 -> frame_error pulses once, write_enable stays low, in_FIFO holds previous value.
REQ-032 rx low pulse of 4 cycles while idle -> FSM returns to IDLE, no output pulses.
REQ-033 Send 0x81 with fifo_full=1 -> overrun pulses once, write_enable low, in_FIFO unchanged.
REQ-034 Assert reset_n=0 during bit 4 of 0xFF, release, then send 0x12 -> only one write_enable with in_FIFO=0x12; with UART_PARITY_EN, wrong parity on 0x12 -> frame_error only.
